bsg_link_downstream_token_fifo: RTL

// - Receive-side stage facing bsg_link_ddr_upstream. Consumes one channel's SDR

---
 rtl/bsg_link_downstream_token_fifo_if.sv | 27 ++
 rtl/bsg_link_downstream_token_fifo.sv | 101 ++++++++++
 2 files changed

// File: rtl/bsg_link_downstream_token_fifo_if.sv
// Flit, core and token signals for bsg_link_downstream_token_fifo.
// The slave modport is the FIFO side; the master modport is the surrounding environment.
interface bsg_link_downstream_token_fifo_if #(
    parameter int unsigned WIDTH_P = 16,
    parameter int unsigned ELS_P   = 16
);
    localparam int unsigned CntW = $clog2(ELS_P) + 1;

    logic               io_valid_i;
    logic [WIDTH_P-1:0] io_data_i;
    logic               core_valid_o;
    logic [WIDTH_P-1:0] core_data_o;
    logic               core_yumi_i;
    logic               token_o;
    logic [CntW-1:0]    free_cnt_o;
    logic               overflow_o;

    modport slave (
        input  io_valid_i, io_data_i, core_yumi_i,
        output core_valid_o, core_data_o, token_o, free_cnt_o, overflow_o
    );

    modport master (
        output io_valid_i, io_data_i, core_yumi_i,
        input  core_valid_o, core_data_o, token_o, free_cnt_o, overflow_o
    );
endinterface

// File: rtl/bsg_link_downstream_token_fifo.sv
// Receive-side credit FIFO for one link channel. Flits from io are buffered
// and handed to core. Each 2**LG_TOKEN_DECIM_P consumed flits return one token upstream.
// Optional macro BSG_LINK_TOKEN_PULSE_EN makes token_o a one-cycle pulse per token.
// Without the macro, token_o is a level that toggles once per token.
module bsg_link_downstream_token_fifo #(
    parameter int unsigned WIDTH_P          = 16,
    parameter int unsigned ELS_P            = 16,
    parameter int unsigned LG_TOKEN_DECIM_P = 3
) (
    input logic clk,
    input logic rst,
    bsg_link_downstream_token_fifo_if.slave link
);
    localparam int unsigned PtrW = $clog2(ELS_P);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] ElsCnt = CntW'(ELS_P);

    logic [WIDTH_P-1:0]          mem_q [ELS_P];
    logic [PtrW-1:0]             wptr_q, wptr_d;
    logic [PtrW-1:0]             rptr_q, rptr_d;
    logic [CntW-1:0]             count_q, count_d;
    logic [LG_TOKEN_DECIM_P-1:0] decim_q, decim_d;
    logic                        token_q, token_d;
    logic                        overflow_q, overflow_d;
    logic                        core_valid;
    logic                        yumi_eff;
    logic                        wr_en;
    logic                        token_wrap;

    // Next-state: pointer/count bookkeeping, token decimation and sticky overflow
    always_comb begin
        core_valid = (count_q != '0);
        // A yumi against an empty FIFO is ignored entirely
        yumi_eff   = link.core_yumi_i && core_valid;
        // A full FIFO still accepts a write when the head leaves in the same cycle
        wr_en      = link.io_valid_i && ((count_q != ElsCnt) || yumi_eff);
        token_wrap = yumi_eff && (&decim_q);

        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        decim_d    = decim_q;
        overflow_d = overflow_q;

        if (wr_en) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (yumi_eff) begin
            rptr_d  = rptr_q + 1'b1;
            decim_d = decim_q + 1'b1;
        end

        unique case ({wr_en, yumi_eff})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (link.io_valid_i && !wr_en) begin
            overflow_d = 1'b1;
        end

`ifdef BSG_LINK_TOKEN_PULSE_EN
        token_d = token_wrap;
`else
        token_d = token_q ^ token_wrap;
`endif
    end

    // Control state register, cleared by asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            decim_q    <= '0;
            token_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            decim_q    <= decim_d;
            token_q    <= token_d;
            overflow_q <= overflow_d;
        end
    end

    // Flit storage; contents are not reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wptr_q] <= link.io_data_i;
        end
    end

    assign link.core_valid_o = core_valid;
    assign link.core_data_o  = core_valid ? mem_q[rptr_q] : '0;
    assign link.free_cnt_o   = ElsCnt - count_q;
    assign link.token_o      = token_q;
    assign link.overflow_o   = overflow_q;
endmodule
